// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline stage registers / fetch unit and
// the central stall/flush sequencer.
interface pipeline_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  // hazard sources
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_reg_write;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_target;
  logic             trap_valid;
  logic [XLEN-1:0]  trap_vector;
  logic             imem_ready;
  logic             dmem_busy;
  // stage controls
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             stall_mem;
  logic             flush_id;
  logic             flush_ex;
  logic             flush_mem;
  logic             pc_redirect_valid;
  logic [XLEN-1:0]  pc_redirect_target;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  // pipeline side: reports hazards, consumes stall/flush controls
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_reg_write, redirect_valid, redirect_target, trap_valid,
           trap_vector, imem_ready, dmem_busy,
    input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
           flush_mem, pc_redirect_valid, pc_redirect_target, stall_cycles,
           flush_events
  );

  // sequencer side
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_reg_write, redirect_valid, redirect_target, trap_valid,
           trap_vector, imem_ready, dmem_busy,
    output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
           flush_mem, pc_redirect_valid, pc_redirect_target, stall_cycles,
           flush_events
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use stalls,
// branch/trap redirects, data-memory freezes and saturating perf counters.
module pipeline_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT, TRAP} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, nxt;
  logic [XLEN-1:0]  tgt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             load_use, take_trap, take_redir;
  logic             s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, pcv;

  assign load_use = bus.ex_mem_read & bus.ex_reg_write & (bus.ex_rd != 5'd0) &
                    ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                     (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

  // Stage controls by priority; everything is forced low while reset is held.
  always_comb begin
    {s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, pcv} = '0;
    take_trap  = 1'b0;
    take_redir = 1'b0;
    nxt        = state;
    if (!reset) begin
      unique case (state)
        RUN, MEM_WAIT: begin
          nxt = RUN;
          if (bus.dmem_busy) begin
            // EX/MEM frozen: trap/redirect stay asserted and are seen later
            {s_if, s_id, s_ex, s_mem} = 4'b1111;
            nxt = MEM_WAIT;
          end else if (bus.trap_valid) begin
            {f_id, f_ex, f_mem} = 3'b111;
            take_trap = 1'b1;
            nxt = TRAP;
          end else if (bus.redirect_valid) begin
            {f_id, f_ex} = 2'b11;
            take_redir = 1'b1;
            nxt = REDIRECT;
          end else if (load_use) begin
            {s_if, s_id, f_ex} = 3'b111;
          end else if (!bus.imem_ready) begin
            {s_if, f_id} = 2'b11;
          end
        end
        REDIRECT, TRAP: begin
          if (bus.dmem_busy) begin
            // redirect deferred until the memory access completes
            {s_if, s_id, s_ex, s_mem} = 4'b1111;
          end else begin
            pcv  = 1'b1;
            f_id = 1'b1;
            nxt  = RUN;
          end
        end
        default: nxt = RUN;
      endcase
    end
  end

  // State and latched redirect address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      tgt   <= '0;
    end else begin
      state <= nxt;
      if (take_trap)       tgt <= bus.trap_vector;
      else if (take_redir) tgt <= bus.redirect_target;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (s_if && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
      if ((take_trap || take_redir) && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  assign bus.stall_if           = s_if;
  assign bus.stall_id           = s_id;
  assign bus.stall_ex           = s_ex;
  assign bus.stall_mem          = s_mem;
  assign bus.flush_id           = f_id;
  assign bus.flush_ex           = f_ex;
  assign bus.flush_mem          = f_mem;
  assign bus.pc_redirect_valid  = pcv;
  assign bus.pc_redirect_target = pcv ? tgt : '0;
  assign bus.stall_cycles       = reset ? '0 : stall_cnt;
  assign bus.flush_events       = reset ? '0 : flush_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected stage controls are queued as
// stimulus is applied and popped on the following negative clock edge.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.XLEN(64), .CNT_W(32)) bus ();
  pipeline_ctrl_if #(.XLEN(64), .CNT_W(4))  sbus ();

  pipeline_ctrl #(.XLEN(64), .CNT_W(32)) dut     (.clk(clk), .reset(reset), .bus(bus));
  pipeline_ctrl #(.XLEN(64), .CNT_W(4))  dut_sat (.clk(clk), .reset(reset), .bus(sbus));

  // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem}
  localparam logic [6:0] C_IDLE  = 7'b0000_000;
  localparam logic [6:0] C_LU    = 7'b1100_010;
  localparam logic [6:0] C_FETCH = 7'b1000_100;
  localparam logic [6:0] C_BR    = 7'b0000_110;
  localparam logic [6:0] C_TRAP  = 7'b0000_111;
  localparam logic [6:0] C_RDR   = 7'b0000_100;
  localparam logic [6:0] C_BUSY  = 7'b1111_000;

  typedef struct packed {
    logic [6:0]  ctl;
    logic        pcv;
    logic [63:0] pct;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input logic [6:0] ctl, input logic pcv, input logic [63:0] pct);
    exp_t e;
    e.ctl = ctl;
    e.pcv = pcv;
    e.pct = pct;
    sb.push_back(e);
  endtask

  // compare one queued expectation at the negedge, then move to posedge+1
  task automatic tick(input string tag);
    exp_t e;
    logic [6:0] obs;
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      obs = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
             bus.flush_id, bus.flush_ex, bus.flush_mem};
      check({tag, "_ctl"}, {57'd0, obs}, {57'd0, e.ctl});
      check({tag, "_pcv"}, {63'd0, bus.pc_redirect_valid}, {63'd0, e.pcv});
      if (e.pcv) check({tag, "_pct"}, bus.pc_redirect_target, e.pct);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_target = '0;
    bus.trap_valid = 1'b0; bus.trap_vector = '0;
    bus.imem_ready = 1'b1; bus.dmem_busy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    sbus.id_rs1 = 5'd0; sbus.id_rs2 = 5'd0;
    sbus.id_uses_rs1 = 1'b0; sbus.id_uses_rs2 = 1'b0;
    sbus.ex_rd = 5'd0; sbus.ex_mem_read = 1'b0; sbus.ex_reg_write = 1'b0;
    sbus.redirect_valid = 1'b0; sbus.redirect_target = '0;
    sbus.trap_valid = 1'b0; sbus.trap_vector = '0;
    sbus.imem_ready = 1'b1; sbus.dmem_busy = 1'b0;

    // reset: outputs low even though a fetch stall would otherwise show
    bus.imem_ready = 1'b0;
    #3;
    check("rst_stall_if", {63'd0, bus.stall_if}, 64'd0);
    check("rst_flush_id", {63'd0, bus.flush_id}, 64'd0);
    check("rst_pcv", {63'd0, bus.pc_redirect_valid}, 64'd0);
    check("rst_stall_cycles", {32'd0, bus.stall_cycles}, 64'd0);
    check("rst_flush_events", {32'd0, bus.flush_events}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.imem_ready = 1'b1;

    // load-use on rs1
    bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd5;
    bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
    expect_out(C_LU, 1'b0, '0); tick("lu_rs1");
    clear_inputs();
    expect_out(C_IDLE, 1'b0, '0); tick("lu_clear");
    // x0 destination never stalls
    bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd0;
    bus.id_rs1 = 5'd0; bus.id_uses_rs1 = 1'b1;
    expect_out(C_IDLE, 1'b0, '0); tick("lu_x0");
    // load-use on rs2
    clear_inputs();
    bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd7;
    bus.id_rs2 = 5'd7; bus.id_uses_rs2 = 1'b1;
    expect_out(C_LU, 1'b0, '0); tick("lu_rs2");
    // matching register that is not read
    bus.id_uses_rs2 = 1'b0; bus.id_rs1 = 5'd7;
    expect_out(C_IDLE, 1'b0, '0); tick("lu_unused");
    clear_inputs();

    // fetch stall
    bus.imem_ready = 1'b0;
    expect_out(C_FETCH, 1'b0, '0); tick("fetch");
    clear_inputs();
    check("stall_cycles_a", {32'd0, bus.stall_cycles}, 64'd3);

    // branch redirect
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'h80;
    expect_out(C_BR, 1'b0, '0); tick("br_accept");
    clear_inputs();
    expect_out(C_RDR, 1'b1, 64'h80); tick("br_issue");
    expect_out(C_IDLE, 1'b0, '0); tick("br_done");
    check("flush_events_br", {32'd0, bus.flush_events}, 64'd1);

    // trap beats a simultaneous redirect
    bus.trap_valid = 1'b1; bus.trap_vector = 64'h100;
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'h80;
    expect_out(C_TRAP, 1'b0, '0); tick("trap_accept");
    clear_inputs();
    expect_out(C_RDR, 1'b1, 64'h100); tick("trap_issue");
    expect_out(C_IDLE, 1'b0, '0); tick("trap_done");
    check("flush_events_trap", {32'd0, bus.flush_events}, 64'd2);

    // fresh counters for the memory-wait case
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.dmem_busy = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 64'h200;
    for (int i = 0; i < 3; i++) begin
      expect_out(C_BUSY, 1'b0, '0); tick("memwait");
    end
    bus.dmem_busy = 1'b0;
    expect_out(C_BR, 1'b0, '0); tick("memwait_accept");
    clear_inputs();
    expect_out(C_RDR, 1'b1, 64'h200); tick("memwait_issue");
    check("stall_cycles_mem", {32'd0, bus.stall_cycles}, 64'd3);
    check("flush_events_mem", {32'd0, bus.flush_events}, 64'd1);

    // asynchronous reset while in REDIRECT
    bus.redirect_valid = 1'b1; bus.redirect_target = 64'h300;
    expect_out(C_BR, 1'b0, '0); tick("rst_mid_accept");
    clear_inputs();
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_pcv", {63'd0, bus.pc_redirect_valid}, 64'd0);
    check("rst_mid_flush_id", {63'd0, bus.flush_id}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    expect_out(C_IDLE, 1'b0, '0); tick("rst_mid_after");
    check("rst_mid_stall_cycles", {32'd0, bus.stall_cycles}, 64'd0);
    check("rst_mid_flush_events", {32'd0, bus.flush_events}, 64'd0);

    // 4-bit stall counter saturates at 15
    sbus.imem_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("sat_count_10", {60'd0, sbus.stall_cycles}, 64'd10);
    repeat (10) @(posedge clk);
    #1;
    check("sat_count_15", {60'd0, sbus.stall_cycles}, 64'd15);
    sbus.imem_ready = 1'b1;

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV64 pipeline. Detects load-use hazards, sequences branch/jump redirects and trap entry, and freezes the pipeline during data-memory waits. Drives the stall/flush inputs of the IF, ID, EX and MEM stage registers and the fetch PC redirect. Also keeps saturating performance counters for stall cycles and flush events.

Parameters:
XLEN, 64, data/address width
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_reg_write  in  1  EX instruction writes rd
redirect_valid  in  1  registered branch_taken or jump_taken from EX
redirect_target  in  XLEN  matching branch/jump target
trap_valid  in  1  trap raised by CSR/trap unit
trap_vector  in  XLEN  trap handler address
imem_ready  in  1  fetch data valid this cycle
dmem_busy  in  1  data memory access outstanding
stall_if, stall_id, stall_ex, stall_mem  out  1  hold the stage register
flush_id, flush_ex, flush_mem  out  1  zero the stage register (bubble)
pc_redirect_valid  out  1  load fetch PC from pc_redirect_target
pc_redirect_target  out  XLEN  registered redirect address
stall_cycles  out  CNT_W  cycles with stall_if=1
flush_events  out  CNT_W  accepted redirects plus traps

Behaviour:
- FSM states: RUN, MEM_WAIT, REDIRECT, TRAP. On reset: state RUN; target register 0; counters 0.
- While reset is high, every output is 0, including combinational outputs.
- Evaluation priority, highest first: dmem_busy > trap > redirect > load-use > fetch-stall.
- RUN, dmem_busy=1:
  - stall_if/id/ex/mem=1, all flushes 0.
  - Next state MEM_WAIT.
  - trap and redirect inputs are ignored; they stay asserted because EX/MEM are frozen.
- MEM_WAIT: same outputs as above while dmem_busy=1. The first cycle with dmem_busy=0 is evaluated exactly like RUN, including pending trap or redirect.
- RUN, trap_valid=1:
  - flush_id=flush_ex=flush_mem=1, no stalls.
  - Latch trap_vector; next state TRAP.
- TRAP, exactly 1 cycle:
  - pc_redirect_valid=1, pc_redirect_target=latched vector, flush_id=1.
  - Next state RUN. Inputs are ignored except dmem_busy, which still takes priority and defers the redirect: stay in TRAP, outputs held.
- RUN, redirect_valid=1 (no trap):
  - flush_id=flush_ex=1.
  - Latch redirect_target; next state REDIRECT.
- REDIRECT: identical to TRAP but uses the latched redirect target.
- Load-use, in RUN only:
  - Condition: ex_mem_read & ex_reg_write & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Response: stall_if=stall_id=1, flush_ex=1, for one cycle only. The next cycle the load has left EX, so the condition clears.
- Fetch stall: in RUN, imem_ready=0 with no higher event gives stall_if=1 and flush_id=1.
- All in-RUN outputs are combinational from inputs. pc_redirect_* are registered: valid exactly one cycle after acceptance.
- stall_cycles increments on every cycle with stall_if=1. flush_events increments on each transition into TRAP or REDIRECT.
- Both counters saturate at all-ones and never wrap.
- Reset asserted mid-operation: immediate return to RUN; no pending redirect is issued after release.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → one cycle of stall_if=stall_id=flush_ex=1. Repeat with ex_rd=0 → no stall.
- Branch: redirect_valid=1, target 0x80 in cycle N → N: flush_id=flush_ex=1. N+1: pc_redirect_valid=1, target 0x80, flush_id=1. N+2: all 0. flush_events=1.
- Trap wins: trap_valid=1 (vector 0x100) and redirect_valid=1 (0x80) in the same cycle → flush_mem=1, then pc_redirect_target=0x100; the redirect is not accepted that cycle.
- Memory wait: dmem_busy=1 for 3 cycles with redirect_valid=1 held → 3 cycles of all four stalls, no flushes. Cycle 4 accepts the redirect. stall_cycles=3.
- Reset during REDIRECT: assert reset asynchronously mid-cycle → all outputs 0 immediately. After release, pc_redirect_valid stays 0 and the counters are 0.
- Saturation with CNT_W=4: hold imem_ready=0 for 20 cycles → stall_cycles stops at 15.
